serial_adder_seq: RTL and testbench



---
 rtl/serial_adder_seq.sv | 109 ++++++++++
 tb/tb_serial_adder_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through one 1-bit
// full-adder cell with a registered carry, one bit per clock.
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic fa_a, fa_b, fa_cin, fa_s, fa_c;
    logic last_bit;

    // The single full-adder cell shared by every bit position.
    assign fa_a     = a_sh_q[0];
    assign fa_b     = b_sh_q[0];
    assign fa_cin   = c_q;
    assign fa_s     = fa_a ^ fa_b ^ fa_cin;
    assign fa_c     = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        c_d     = c_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    c_d     = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = {fa_s, acc_q[WIDTH-1:1]};
                c_d    = fa_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: cycle model of the 8-bit instance
// plus directed cases, and an exhaustive sweep of a 4-bit instance.
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum_out;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
    );

    serial_adder_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
    );

    // Behavioural model: an accepted start schedules the exact sum WIDTH edges later.
    int         m_remaining = 0;
    logic [8:0] m_pending = '0;
    logic       m_done = 1'b0;
    logic [7:0] m_sum = '0;
    logic       m_cout = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_remaining = 0;
            m_done      = 1'b0;
            m_sum       = '0;
            m_cout      = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_remaining > 0) begin
                m_remaining = m_remaining - 1;
                if (m_remaining == 0) begin
                    m_done = 1'b1;
                    {m_cout, m_sum} = m_pending;
                end
            end else if (start) begin
                m_pending   = {1'b0, a_in} + {1'b0, b_in} + {8'd0, cin};
                m_remaining = 8;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks = checks + 4;
            if (busy !== (m_remaining > 0)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (m_remaining > 0));
            end
            if (done !== m_done) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, m_done);
            end
            if (sum_out !== m_sum) begin
                errors++;
                $display("FAIL sum_out cyc=%0d got=%h exp=%h", cyc, sum_out, m_sum);
            end
            if (cout !== m_cout) begin
                errors++;
                $display("FAIL cout cyc=%0d got=%b exp=%b", cyc, cout, m_cout);
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; counts busy cycles on the way.
    task automatic wait_done(input int limit, output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout limit=%0d", limit);
        end
    endtask

    initial begin
        int  bc;
        bit  ok;
        int  t1, t2, ndone;
        logic [4:0] exp5;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_sum", 32'(sum_out), 32'd0);
        check_val("reset_cout", 32'(cout), 32'd0);

        // 0x5A + 0x3C
        do_start(8'h5A, 8'h3C, 1'b0);
        wait_done(20, bc, ok);
        check_val("t1_busy_cycles", 32'(bc), 32'd8);
        check_val("t1_sum", 32'(sum_out), 32'h96);
        check_val("t1_cout", 32'(cout), 32'd0);
        check_val("t1_busy_in_done", 32'(busy), 32'd0);
        $display("txn 5a+3c+0 -> sum=%h cout=%b busy_cycles=%0d", sum_out, cout, bc);

        do_start(8'hFF, 8'h01, 1'b0);
        wait_done(20, bc, ok);
        check_val("t2_sum", 32'(sum_out), 32'h00);
        check_val("t2_cout", 32'(cout), 32'd1);
        $display("txn ff+01+0 -> sum=%h cout=%b", sum_out, cout);

        do_start(8'hFF, 8'hFF, 1'b1);
        wait_done(20, bc, ok);
        check_val("t3_sum", 32'(sum_out), 32'hFF);
        check_val("t3_cout", 32'(cout), 32'd1);
        $display("txn ff+ff+1 -> sum=%h cout=%b", sum_out, cout);

        // Start pulsed during RUN must be ignored.
        do_start(8'h01, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a_in  = 8'hF0;
        b_in  = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(20, bc, ok);
        check_val("t4_sum", 32'(sum_out), 32'h02);
        check_val("t4_cout", 32'(cout), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check_val("t4_extra_done", 32'(ndone), 32'd0);
        $display("txn 01+01+0 (ignored f0+0f) -> sum=%h cout=%b", sum_out, cout);

        // Reset at RUN cycle 4 discards the addition and clears the result.
        do_start(8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check_val("t5_done_after_rst", 32'(ndone), 32'd0);
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_sum", 32'(sum_out), 32'h00);
        check_val("t5_cout", 32'(cout), 32'd0);
        $display("txn 80+80+0 aborted by reset -> sum=%h cout=%b", sum_out, cout);

        do_start(8'h10, 8'h20, 1'b0);
        wait_done(20, bc, ok);
        check_val("t6_sum", 32'(sum_out), 32'h30);
        check_val("t6_cout", 32'(cout), 32'd0);
        $display("txn 10+20+0 -> sum=%h cout=%b", sum_out, cout);

        // Back-to-back with start held high.
        @(negedge clk);
        a_in  = 8'h01;
        b_in  = 8'h02;
        cin   = 1'b1;
        start = 1'b1;
        wait_done(20, bc, ok);
        t1 = cyc;
        check_val("t7a_sum", 32'(sum_out), 32'h04);
        check_val("t7a_cout", 32'(cout), 32'd0);
        $display("txn 01+02+1 -> sum=%h cout=%b", sum_out, cout);
        a_in = 8'h7F;
        b_in = 8'h01;
        cin  = 1'b0;
        wait_done(20, bc, ok);
        t2 = cyc;
        start = 1'b0;
        check_val("t7_spacing", 32'(t2 - t1), 32'd9);
        check_val("t7b_sum", 32'(sum_out), 32'h80);
        check_val("t7b_cout", 32'(cout), 32'd0);
        $display("txn 7f+01+0 -> sum=%h cout=%b spacing=%0d", sum_out, cout, t2 - t1);
        repeat (12) @(negedge clk);

        // Exhaustive 4-bit sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a4     = 4'(a);
                    b4     = 4'(b);
                    cin4   = 1'(c);
                    start4 = 1'b1;
                    @(posedge clk);
                    #1 start4 = 1'b0;
                    ok = 1'b0;
                    for (int i = 0; i < 12; i++) begin
                        @(negedge clk);
                        if (busy4 === 1'b1 && done4 === 1'b1) begin
                            checks++;
                            errors++;
                            $display("FAIL w4_busy_done_overlap a=%0h b=%0h", a, b);
                        end
                        if (done4 === 1'b1) begin
                            ok = 1'b1;
                            break;
                        end
                    end
                    exp5 = 5'(a + b + c);
                    if (!ok) begin
                        checks++;
                        errors++;
                        $display("FAIL w4_timeout a=%0h b=%0h cin=%0d", a, b, c);
                    end else begin
                        check_val("w4_result", 32'({cout4, sum4}), 32'(exp5));
                    end
                    $display("txn w4 %0h+%0h+%0d -> cout=%b sum=%h", a, b, c, cout4, sum4);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
